// File: rtl/msm_double_add_sequencer_pkg.sv
// elliptic_curve_structs: shared curve types for the MSM datapath.
//   P_WIDTH        field element width
//   SCALAR_WIDTH   scalar width
//   curve_point_t  affine point {x, y}
//   ec_op_t        operation selector for the shared EC point unit
//   msb_index()    priority encoder used by the zero-skip cursor (MSM_SKIP_ZERO_EN)
package elliptic_curve_structs;

    localparam int P_WIDTH      = 16;
    localparam int SCALAR_WIDTH = 8;
    localparam int SCALAR_IDX_W = (SCALAR_WIDTH > 1) ? $clog2(SCALAR_WIDTH) : 1;

    typedef struct packed {
        logic [P_WIDTH-1:0] x;
        logic [P_WIDTH-1:0] y;
    } curve_point_t;

    typedef enum logic {
        EC_OP_ADD = 1'b0,
        EC_OP_DBL = 1'b1
    } ec_op_t;

    function automatic logic [SCALAR_IDX_W-1:0] msb_index(input logic [SCALAR_WIDTH-1:0] v);
        logic [SCALAR_IDX_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < SCALAR_WIDTH; k++) begin
            if (v[k]) begin
                idx = SCALAR_IDX_W'(k);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/msm_double_add_sequencer_cursor.sv
// msm_bit_cursor: pair index i and bit index b for the MSB-first scan.
// Ports:
//   clk, Reset        clock, synchronous active-high reset
//   x[length]         scalars (stable while the sequencer is busy)
//   load              i=0, b=MSB (start of a run)
//   step_bit          b--
//   next_pair         i++, b=MSB
//   jump_msb          b = highest set bit of x[i] at or below b (MSM_SKIP_ZERO_EN only)
//   pair_idx/bit_idx  current i / b
//   bit_val           x[i][b]
//   bit_last          b == 0
//   pair_last         i == length-1
//   rest_zero         no set bit of x[i] at or below b (always 0 without MSM_SKIP_ZERO_EN)
// Macro: MSM_SKIP_ZERO_EN enables the leading-zero skip.
module msm_bit_cursor
    import elliptic_curve_structs::*;
#(
    parameter int length = 10,
    localparam int IDX_W = (length > 1) ? $clog2(length) : 1
) (
    input  logic                    clk,
    input  logic                    Reset,
    input  logic [SCALAR_WIDTH-1:0] x [length],
    input  logic                    load,
    input  logic                    step_bit,
    input  logic                    next_pair,
    input  logic                    jump_msb,
    output logic [IDX_W-1:0]        pair_idx,
    output logic [SCALAR_IDX_W-1:0] bit_idx,
    output logic                    bit_val,
    output logic                    bit_last,
    output logic                    pair_last,
    output logic                    rest_zero
);

    localparam logic [SCALAR_IDX_W-1:0] BIT_MSB = SCALAR_IDX_W'(SCALAR_WIDTH - 1);

    logic [IDX_W-1:0]        pair_idx_q, pair_idx_d;
    logic [SCALAR_IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [SCALAR_WIDTH-1:0] x_cur;

    assign x_cur     = x[pair_idx_q];
    assign bit_val   = x_cur[bit_idx_q];
    assign bit_last  = (bit_idx_q == '0);
    assign pair_last = (pair_idx_q == IDX_W'(length - 1));
    assign pair_idx  = pair_idx_q;
    assign bit_idx   = bit_idx_q;

`ifdef MSM_SKIP_ZERO_EN
    logic [SCALAR_WIDTH-1:0] x_rest;
    // Only bits at or below the cursor are still to be visited; masking the
    // upper ones keeps a jump from ever moving b back up mid-scalar.
    assign x_rest    = x_cur & ((SCALAR_WIDTH'(2) << bit_idx_q) - SCALAR_WIDTH'(1));
    assign rest_zero = (x_rest == '0);
`else
    logic unused_jump_msb;
    assign unused_jump_msb = jump_msb;
    assign rest_zero       = 1'b0;
`endif

    always_comb begin
        pair_idx_d = pair_idx_q;
        bit_idx_d  = bit_idx_q;
        if (load) begin
            pair_idx_d = '0;
            bit_idx_d  = BIT_MSB;
        end else if (next_pair) begin
            pair_idx_d = pair_idx_q + IDX_W'(1);
            bit_idx_d  = BIT_MSB;
        end else if (step_bit) begin
            bit_idx_d = bit_idx_q - SCALAR_IDX_W'(1);
        end
`ifdef MSM_SKIP_ZERO_EN
        else if (jump_msb) begin
            bit_idx_d = msb_index(x_rest);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            pair_idx_q <= '0;
            bit_idx_q  <= BIT_MSB;
        end else begin
            pair_idx_q <= pair_idx_d;
            bit_idx_q  <= bit_idx_d;
        end
    end

endmodule

// File: rtl/msm_double_add_sequencer.sv
// msm_double_add_sequencer: MSB-first double-and-add sequencer for
// R = sum x[i]*G[i], driving one shared EC point unit with a start/done
// handshake. The point at infinity is tracked with flags so the unit never
// receives an infinity operand. Each pair i is scanned into acc, then folded
// into the running sum S before the next pair starts.
// Ports:
//   clk, Reset              clock, synchronous active-high reset
//   start                   begin a run (accepted only in IDLE)
//   G[length], x[length]    base points / scalars, stable while busy
//   R, R_inf                result and its infinity flag, valid while Done
//   Done                    held from end of run until next accepted start
//   busy                    run in progress
//   op_start, op_sel        one-cycle launch pulse, ADD (P+Q) or DBL (2P)
//   op_P, op_Q              registered operands, stable until op_done
//   op_done, op_R, op_R_inf result handshake from the point unit
// Macro: MSM_SKIP_ZERO_EN skips leading zero bits (and all-zero scalars)
// while the accumulator is at infinity; op sequence and result unchanged.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start; Done/R hold the last result
// BIT      | new bit: double acc unless it is infinity
// DBL_WAIT | waiting for the DBL result
// ADD      | add G[i] if x[i][b]=1 (plain copy when acc is infinity)
// ADD_WAIT | waiting for the ADD result
// NEXT     | step to the next lower bit, or finish the pair
// SUM      | fold acc into S (copy/skip when either is infinity)
// SUM_WAIT | waiting for the S+acc result
// FIN      | publish S as R, raise Done
module msm_double_add_sequencer
    import elliptic_curve_structs::*;
#(
    parameter int length = 10,
    localparam int IDX_W = (length > 1) ? $clog2(length) : 1
) (
    input  logic                    clk,
    input  logic                    Reset,
    input  logic                    start,
    input  curve_point_t            G [length],
    input  logic [SCALAR_WIDTH-1:0] x [length],
    output curve_point_t            R,
    output logic                    R_inf,
    output logic                    Done,
    output logic                    busy,
    output logic                    op_start,
    output ec_op_t                  op_sel,
    output curve_point_t            op_P,
    output curve_point_t            op_Q,
    input  logic                    op_done,
    input  curve_point_t            op_R,
    input  logic                    op_R_inf
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_BIT      = 4'd1;
    localparam logic [3:0] S_DBL_WAIT = 4'd2;
    localparam logic [3:0] S_ADD      = 4'd3;
    localparam logic [3:0] S_ADD_WAIT = 4'd4;
    localparam logic [3:0] S_NEXT     = 4'd5;
    localparam logic [3:0] S_SUM      = 4'd6;
    localparam logic [3:0] S_SUM_WAIT = 4'd7;
    localparam logic [3:0] S_FIN      = 4'd8;

    logic [3:0]   state_q, state_d;
    curve_point_t acc_q, acc_d;
    logic         acc_inf_q, acc_inf_d;
    curve_point_t s_q, s_d;
    logic         s_inf_q, s_inf_d;
    curve_point_t r_q, r_d;
    logic         r_inf_q, r_inf_d;
    logic         done_q, done_d;
    logic         busy_q, busy_d;
    logic         op_start_q, op_start_d;
    ec_op_t       op_sel_q, op_sel_d;
    curve_point_t op_p_q, op_p_d;
    curve_point_t op_q_q, op_q_d;

    logic                    load, step_bit, next_pair, jump_msb, pair_done;
    logic [IDX_W-1:0]        pair_idx;
    logic [SCALAR_IDX_W-1:0] bit_idx;
    logic                    bit_val, bit_last, pair_last, rest_zero;

    msm_bit_cursor #(
        .length (length)
    ) u_cursor (
        .clk       (clk),
        .Reset     (Reset),
        .x         (x),
        .load      (load),
        .step_bit  (step_bit),
        .next_pair (next_pair),
        .jump_msb  (jump_msb),
        .pair_idx  (pair_idx),
        .bit_idx   (bit_idx),
        .bit_val   (bit_val),
        .bit_last  (bit_last),
        .pair_last (pair_last),
        .rest_zero (rest_zero)
    );

`ifndef MSM_SKIP_ZERO_EN
    logic                    unused_rest_zero;
    logic [SCALAR_IDX_W-1:0] unused_bit_idx;
    assign unused_rest_zero = rest_zero;
    assign unused_bit_idx   = bit_idx;
`else
    logic [SCALAR_IDX_W-1:0] unused_bit_idx;
    assign unused_bit_idx = bit_idx;
`endif

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        acc_inf_d  = acc_inf_q;
        s_d        = s_q;
        s_inf_d    = s_inf_q;
        r_d        = r_q;
        r_inf_d    = r_inf_q;
        done_d     = done_q;
        busy_d     = busy_q;
        op_start_d = 1'b0;
        op_sel_d   = op_sel_q;
        op_p_d     = op_p_q;
        op_q_d     = op_q_q;
        load       = 1'b0;
        step_bit   = 1'b0;
        next_pair  = 1'b0;
        jump_msb   = 1'b0;
        pair_done  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_inf_d = 1'b1;
                    s_inf_d   = 1'b1;
                    load      = 1'b1;
                    done_d    = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_BIT;
                end
            end
            S_BIT: begin
                if (acc_inf_q) begin
`ifdef MSM_SKIP_ZERO_EN
                    if (rest_zero) begin
                        pair_done = 1'b1;
                    end else begin
                        jump_msb = 1'b1;
                        state_d  = S_ADD;
                    end
`else
                    state_d = S_ADD;
`endif
                end else begin
                    op_start_d = 1'b1;
                    op_sel_d   = EC_OP_DBL;
                    op_p_d     = acc_q;
                    state_d    = S_DBL_WAIT;
                end
            end
            S_DBL_WAIT: begin
                if (op_done) begin
                    acc_d     = op_R;
                    acc_inf_d = op_R_inf;
                    state_d   = S_ADD;
                end
            end
            S_ADD: begin
                if (!bit_val) begin
                    state_d = S_NEXT;
                end else if (acc_inf_q) begin
                    acc_d     = G[pair_idx];
                    acc_inf_d = 1'b0;
                    state_d   = S_NEXT;
                end else begin
                    op_start_d = 1'b1;
                    op_sel_d   = EC_OP_ADD;
                    op_p_d     = acc_q;
                    op_q_d     = G[pair_idx];
                    state_d    = S_ADD_WAIT;
                end
            end
            S_ADD_WAIT: begin
                if (op_done) begin
                    acc_d     = op_R;
                    acc_inf_d = op_R_inf;
                    state_d   = S_NEXT;
                end
            end
            S_NEXT: begin
                if (!bit_last) begin
                    step_bit = 1'b1;
                    state_d  = S_BIT;
                end else begin
                    state_d = S_SUM;
                end
            end
            S_SUM: begin
                if (acc_inf_q) begin
                    pair_done = 1'b1;
                end else if (s_inf_q) begin
                    s_d       = acc_q;
                    s_inf_d   = 1'b0;
                    pair_done = 1'b1;
                end else begin
                    op_start_d = 1'b1;
                    op_sel_d   = EC_OP_ADD;
                    op_p_d     = s_q;
                    op_q_d     = acc_q;
                    state_d    = S_SUM_WAIT;
                end
            end
            S_SUM_WAIT: begin
                if (op_done) begin
                    s_d       = op_R;
                    s_inf_d   = op_R_inf;
                    pair_done = 1'b1;
                end
            end
            S_FIN: begin
                r_d     = s_q;
                r_inf_d = s_inf_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A finished pair starts the next one with a fresh (infinite) acc.
        if (pair_done) begin
            if (pair_last) begin
                state_d = S_FIN;
            end else begin
                next_pair = 1'b1;
                acc_inf_d = 1'b1;
                state_d   = S_BIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            acc_inf_q  <= 1'b1;
            s_q        <= '0;
            s_inf_q    <= 1'b1;
            r_q        <= '0;
            r_inf_q    <= 1'b1;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            op_start_q <= 1'b0;
            op_sel_q   <= EC_OP_DBL;
            op_p_q     <= '0;
            op_q_q     <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            acc_inf_q  <= acc_inf_d;
            s_q        <= s_d;
            s_inf_q    <= s_inf_d;
            r_q        <= r_d;
            r_inf_q    <= r_inf_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            op_start_q <= op_start_d;
            op_sel_q   <= op_sel_d;
            op_p_q     <= op_p_d;
            op_q_q     <= op_q_d;
        end
    end

    assign R        = r_q;
    assign R_inf    = r_inf_q;
    assign Done     = done_q;
    assign busy     = busy_q;
    assign op_start = op_start_q;
    assign op_sel   = op_sel_q;
    assign op_P     = op_p_q;
    assign op_Q     = op_q_q;

endmodule

// File: tb/tb_msm_double_add_sequencer.sv
// Bench for msm_double_add_sequencer. The EC unit is a stand-in abelian
// group (componentwise addition mod 2^P_WIDTH, identity = (0,0)) with a
// fixed 5-cycle latency, so the expected R is a plain weighted sum.
module tb_msm_double_add_sequencer;
    import elliptic_curve_structs::*;

    localparam int LEN    = 10;
    localparam int LAT    = 5;
    localparam int BUDGET = 5000;
    localparam int NVEC   = 11;

    logic                    clk;
    logic                    Reset;
    logic                    start;
    curve_point_t            G [LEN];
    logic [SCALAR_WIDTH-1:0] x [LEN];
    curve_point_t            R;
    logic                    R_inf;
    logic                    Done;
    logic                    busy;
    logic                    op_start;
    ec_op_t                  op_sel;
    curve_point_t            op_P;
    curve_point_t            op_Q;
    logic                    op_done;
    curve_point_t            op_R;
    logic                    op_R_inf;

    int checks = 0;
    int errors = 0;
    int n_dbl  = 0;
    int n_add  = 0;
    int pend   = 0;

    msm_double_add_sequencer #(
        .length (LEN)
    ) dut (
        .clk      (clk),
        .Reset    (Reset),
        .start    (start),
        .G        (G),
        .x        (x),
        .R        (R),
        .R_inf    (R_inf),
        .Done     (Done),
        .busy     (busy),
        .op_start (op_start),
        .op_sel   (op_sel),
        .op_P     (op_P),
        .op_Q     (op_Q),
        .op_done  (op_done),
        .op_R     (op_R),
        .op_R_inf (op_R_inf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // EC unit stand-in: one op at a time, result LAT cycles after op_start.
    initial begin
        ec_op_t       cap_sel;
        curve_point_t cap_p, cap_q, res;
        cap_sel  = EC_OP_DBL;
        cap_p    = '0;
        cap_q    = '0;
        res      = '0;
        op_done  = 1'b0;
        op_R     = '0;
        op_R_inf = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            op_done = 1'b0;
            if (op_start) begin
                check("op_no_overlap", 64'(pend), 64'd0);
                cap_sel = op_sel;
                cap_p   = op_P;
                cap_q   = op_Q;
                if (op_sel == EC_OP_DBL) begin
                    n_dbl++;
                    res.x = op_P.x + op_P.x;
                    res.y = op_P.y + op_P.y;
                end else begin
                    n_add++;
                    res.x = op_P.x + op_Q.x;
                    res.y = op_P.y + op_Q.y;
                end
                pend = LAT;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    if (busy) begin
                        check("op_operands_stable",
                              {31'd0, (op_P !== cap_p) || (op_sel !== cap_sel) ||
                               (cap_sel == EC_OP_ADD && op_Q !== cap_q)}, 64'd0);
                    end
                    op_R     = res;
                    op_R_inf = (res == '0);
                    op_done  = 1'b1;
                end
            end
        end
    end

    typedef struct {
        logic [LEN*SCALAR_WIDTH-1:0] xv;
        int                          exp_dbl;
        int                          exp_add;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic ref_msm(input logic [LEN*SCALAR_WIDTH-1:0] xv,
                           output curve_point_t r, output logic r_inf);
        int sx, sy;
        logic any;
        sx  = 0;
        sy  = 0;
        any = 1'b0;
        for (int i = 0; i < LEN; i++) begin
            sx += int'(xv[i*SCALAR_WIDTH +: SCALAR_WIDTH]) * int'(G[i].x);
            sy += int'(xv[i*SCALAR_WIDTH +: SCALAR_WIDTH]) * int'(G[i].y);
            if (xv[i*SCALAR_WIDTH +: SCALAR_WIDTH] != '0) any = 1'b1;
        end
        r.x   = P_WIDTH'(sx);
        r.y   = P_WIDTH'(sy);
        r_inf = !any || (r == '0);
    endtask

    task automatic load_x(input logic [LEN*SCALAR_WIDTH-1:0] xv);
        for (int i = 0; i < LEN; i++) x[i] = xv[i*SCALAR_WIDTH +: SCALAR_WIDTH];
    endtask

    task automatic run_msm(input int poke_at, output int cycles);
        @(negedge clk);
        n_dbl = 0;
        n_add = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("accept_busy", busy, 1);
        check("accept_done_drop", Done, 0);
        cycles = 1;
        while (!Done && cycles < BUDGET) begin
            start = (poke_at != 0) && (cycles == poke_at);
            if (start) check("poke_while_busy", busy, 1);
            @(posedge clk);
            #1;
            cycles++;
        end
        start = 1'b0;
        check("run_done", Done, 1);
        check("run_idle", busy, 0);
    endtask

    task automatic check_result(input string tag, input logic [LEN*SCALAR_WIDTH-1:0] xv,
                                input int exp_dbl, input int exp_add);
        curve_point_t er;
        logic         einf;
        ref_msm(xv, er, einf);
        check({tag, "_R_inf"}, R_inf, einf);
        if (!einf) check({tag, "_R"}, R, er);
        check({tag, "_n_dbl"}, 64'(n_dbl), 64'(exp_dbl));
        check({tag, "_n_add"}, 64'(n_add), 64'(exp_add));
    endtask

    initial begin
        int cycles;
        int guard;
        int ops_at_reset;
        logic [LEN*SCALAR_WIDTH-1:0] xv3;

        for (int i = 0; i < LEN; i++) begin
            G[i].x = P_WIDTH'(11 * (i + 1));
            G[i].y = P_WIDTH'(300 + 17 * i);
            x[i]   = '0;
        end
        Reset = 1'b1;
        start = 1'b0;

        for (int k = 0; k < NVEC; k++) vecs[k].xv = '0;
        vecs[0].exp_dbl  = 0;  vecs[0].exp_add  = 0;
        vecs[1].xv[7:0]  = 8'h01;
        vecs[1].exp_dbl  = 0;  vecs[1].exp_add  = 0;
        vecs[2].xv[7:0]  = 8'h03;
        vecs[2].exp_dbl  = 1;  vecs[2].exp_add  = 1;
        vecs[3].xv[7:0]  = 8'hFF;
        vecs[3].exp_dbl  = 7;  vecs[3].exp_add  = 7;
        vecs[4].xv[7:0]  = 8'h80;
        vecs[4].exp_dbl  = 7;  vecs[4].exp_add  = 0;
        vecs[5].xv[15:0] = 16'h0101;
        vecs[5].exp_dbl  = 0;  vecs[5].exp_add  = 1;
        vecs[6].xv[79:72] = 8'h05;
        vecs[6].exp_dbl  = 2;  vecs[6].exp_add  = 1;
        vecs[7].xv[7:0]   = 8'h02;
        vecs[7].xv[31:24] = 8'h06;
        vecs[7].xv[79:72] = 8'h81;
        vecs[7].exp_dbl  = 10; vecs[7].exp_add  = 4;
        for (int i = 0; i < LEN; i++) vecs[8].xv[i*8 +: 8] = 8'h01;
        vecs[8].exp_dbl  = 0;  vecs[8].exp_add  = 9;
        for (int i = 0; i < LEN; i++) vecs[9].xv[i*8 +: 8] = 8'hFF;
        vecs[9].exp_dbl  = 70; vecs[9].exp_add  = 79;
        for (int i = 0; i < LEN; i++) vecs[10].xv[i*8 +: 8] = 8'(i + 1);
        vecs[10].exp_dbl = 19; vecs[10].exp_add = 16;

        repeat (3) @(posedge clk);
        #1;
        Reset = 1'b0;

        check("rst_Done", Done, 0);
        check("rst_busy", busy, 0);
        check("rst_op_start", op_start, 0);
        check("rst_R", R, 0);
        check("rst_R_inf", R_inf, 1);
        check("rst_op_sel", op_sel, EC_OP_DBL);
        check("rst_op_P", op_P, 0);
        check("rst_op_Q", op_Q, 0);

        for (int k = 0; k < NVEC; k++) begin
            load_x(vecs[k].xv);
            run_msm(0, cycles);
            check_result($sformatf("vec%0d", k), vecs[k].xv, vecs[k].exp_dbl, vecs[k].exp_add);
        end

        // Done and R hold in IDLE until the next accepted start.
        repeat (5) @(posedge clk);
        #1;
        check("done_held", Done, 1);
        check_result("held", vecs[NVEC-1].xv, vecs[NVEC-1].exp_dbl, vecs[NVEC-1].exp_add);

        // start pulsed mid-run must not restart or disturb the run.
        load_x(vecs[9].xv);
        run_msm(30, cycles);
        check_result("poke", vecs[9].xv, vecs[9].exp_dbl, vecs[9].exp_add);

        // Reset while a DBL is outstanding; the late op_done must be ignored.
        xv3 = vecs[2].xv;
        load_x(xv3);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        guard = 0;
        while (!(op_start && op_sel == EC_OP_DBL) && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("dbl_issued", {63'd0, op_start}, 64'd1);
        @(posedge clk);
        #1;
        Reset = 1'b1;
        @(posedge clk);
        #1;
        Reset = 1'b0;
        ops_at_reset = n_dbl + n_add;
        check("reset_busy_drop", busy, 0);
        guard = 0;
        while (pend != 0 && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        repeat (4) @(posedge clk);
        #1;
        check("late_done_drained", 64'(pend), 64'd0);
        check("late_done_Done", Done, 0);
        check("late_done_busy", busy, 0);
        check("late_done_R_inf", R_inf, 1);
        check("late_done_no_ops", 64'(n_dbl + n_add), 64'(ops_at_reset));
        run_msm(0, cycles);
        check_result("rerun", xv3, 1, 1);

        // Leading-zero skip shortens the x0=1 run; otherwise every bit is visited.
        load_x(vecs[1].xv);
        run_msm(0, cycles);
        check_result("skip", vecs[1].xv, 0, 0);
`ifdef MSM_SKIP_ZERO_EN
        check("skip_cycles_short", {63'd0, cycles < 40}, 64'd1);
`else
        check("full_scan_cycles", {63'd0, cycles >= 240}, 64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
